// File: rtl/rej_sample_collector.sv
// Splits 24-bit squeeze chunks into two 12-bit candidates, keeps those < Q, streams them out with an index.
// Latency: chunk handshake at t -> coef_valid at t+1; up to 2 coefficients per chunk.
// Backpressure: in_ready only when the two-slot buffer drains this cycle; outputs hold while !coef_ready.
module rej_sample_collector #(
    parameter int unsigned Q      = 3329,
    parameter int unsigned N_COEF = 256,
    parameter int unsigned CNT_W  = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [23:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [11:0] coef_data,
    output logic [7:0]  coef_idx,
    output logic        coef_valid,
    input  logic        coef_ready,
    output logic        busy,
    output logic        done
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_nxt;
    logic [11:0]      slot0, slot1, slot0_nxt, slot1_nxt;
    logic [1:0]       pend_cnt, pend_nxt;
    logic [CNT_W-1:0] out_cnt, out_nxt;
    logic             done_nxt;

    logic             run, pop, load, last, acc1, acc2;
    logic [11:0]      d1, d2;
    logic [CNT_W:0]   cnt_after_pop;

    // b0 plus the low nibble of b1 form d1; b2 plus the high nibble of b1 form d2
    assign d1   = in_data[11:0];
    assign d2   = in_data[23:12];
    assign acc1 = d1 < 12'(Q);
    assign acc2 = d2 < 12'(Q);

    assign run           = (state == RUN);
    assign pop           = run && (pend_cnt != 2'd0) && coef_ready;
    assign cnt_after_pop = {1'b0, out_cnt} + (CNT_W+1)'(pop);
    // New chunks land only in an empty buffer, and never once the last index has been claimed
    assign in_ready      = run && (pend_cnt == {1'b0, pop}) && (cnt_after_pop < (CNT_W+1)'(N_COEF));
    assign load          = in_valid && in_ready;
    assign last          = pop && (out_cnt == CNT_W'(N_COEF - 1));

    assign busy       = run;
    assign coef_valid = run && (pend_cnt != 2'd0);
    assign coef_data  = run ? slot0 : 12'd0;
    assign coef_idx   = run ? out_cnt[7:0] : 8'd0;

    always_comb begin
        state_nxt = state;
        slot0_nxt = slot0;
        slot1_nxt = slot1;
        pend_nxt  = pend_cnt;
        out_nxt   = out_cnt;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                    out_nxt   = '0;
                    pend_nxt  = 2'd0;
                end
            end
            RUN: begin
                if (pop) begin
                    out_nxt   = out_cnt + 1'b1;
                    slot0_nxt = slot1;
                    pend_nxt  = pend_cnt - 2'd1;
                end
                if (load) begin
                    pend_nxt  = {1'b0, acc1} + {1'b0, acc2};
                    slot0_nxt = acc1 ? d1 : d2;
                    slot1_nxt = d2;
                end
                // Final pop: anything still buffered belongs to no coefficient slot
                if (last) begin
                    state_nxt = IDLE;
                    pend_nxt  = 2'd0;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            slot0    <= '0;
            slot1    <= '0;
            pend_cnt <= 2'd0;
            out_cnt  <= '0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            slot0    <= slot0_nxt;
            slot1    <= slot1_nxt;
            pend_cnt <= pend_nxt;
            out_cnt  <= out_nxt;
            done     <= done_nxt;
        end
    end

endmodule
